// File: rtl/mem_test_master_if.sv
// Avalon-MM single-word bus between mem_test_master and a word-addressed memory slave.
interface mem_test_master_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_waitrequest;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/mem_test_master.sv
// Avalon-MM master that fills a memory with seed+i, or reads it back with
// pipelined reads and counts words that differ from that pattern.
module mem_test_master #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  mem_test_master_if.master avm
);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_FIN} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [CNT_W-1:0]  idx_q, idx_d;   // words written, or reads issued
  logic [CNT_W-1:0]  rsp_q, rsp_d;   // read responses checked
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              busy_d, done_d, read_d, write_d;
  logic [15:0]       err_d;
  logic [ADDR_W-1:0] first_d, addr_d;
  logic [DATA_W-1:0] wdata_d;

  logic              wr_acc_c, rd_acc_c, rsp_c, miss_c;
  logic [CNT_W-1:0]  idx_inc_c, rsp_inc_c;

  assign wr_acc_c  = (state_q == S_WR) && avm.avm_write && !avm.avm_waitrequest;
  assign rd_acc_c  = (state_q == S_RD) && avm.avm_read && !avm.avm_waitrequest;
  assign rsp_c     = (state_q == S_RD) && avm.avm_readdatavalid;
  assign idx_inc_c = idx_q + CNT_W'(1);
  assign rsp_inc_c = rsp_q + CNT_W'(1);
  assign miss_c    = rsp_c && (avm.avm_readdata != (seed_q + DATA_W'(rsp_q)));

  assign avm.avm_byteenable = '1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (word_count == '0) state_d = S_FIN;
        else if (mode)        state_d = S_RD;
        else                  state_d = S_WR;
      end
      S_WR:  if (wr_acc_c && (idx_inc_c == count_q)) state_d = S_FIN;
      S_RD:  if (rsp_c && (rsp_inc_c == count_q))    state_d = S_FIN;
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of every registered output and counter.
  always_comb begin
    base_d  = base_q;
    count_d = count_q;
    seed_d  = seed_q;
    idx_d   = idx_q;
    rsp_d   = rsp_q;
    pend_d  = pend_q;
    err_d   = err_count;
    first_d = first_err_addr;
    addr_d  = avm.avm_address;
    wdata_d = avm.avm_writedata;
    case (state_q)
      S_IDLE: if (start) begin
        base_d  = base_addr;
        count_d = word_count;
        seed_d  = seed;
        idx_d   = '0;
        rsp_d   = '0;
        pend_d  = '0;
        err_d   = '0;
        first_d = '0;
        addr_d  = base_addr;
        wdata_d = seed;
      end
      S_WR: if (wr_acc_c) begin
        idx_d   = idx_inc_c;
        addr_d  = base_q + ADDR_W'(idx_inc_c);
        wdata_d = seed_q + DATA_W'(idx_inc_c);
      end
      S_RD: begin
        if (rd_acc_c) begin
          idx_d  = idx_inc_c;
          addr_d = base_q + ADDR_W'(idx_inc_c);
        end
        if (rsp_c) rsp_d = rsp_inc_c;
        pend_d = pend_q + PEND_W'(rd_acc_c) - PEND_W'(rsp_c);
        if (miss_c) begin
          if (err_count != 16'hFFFF) err_d = err_count + 16'd1;
          if (err_count == 16'd0)    first_d = base_q + ADDR_W'(rsp_q);
        end
      end
      default: ;
    endcase
    busy_d  = (state_d == S_WR) || (state_d == S_RD);
    done_d  = (state_d == S_FIN);
    write_d = (state_d == S_WR);
    // Throttle on the post-edge pending count so a stalled request never drops.
    read_d  = (state_d == S_RD) && (idx_d < count_d) && (pend_d < PEND_W'(MAX_PENDING));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q            <= '0;
      count_q           <= '0;
      seed_q            <= '0;
      idx_q             <= '0;
      rsp_q             <= '0;
      pend_q            <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err_count         <= '0;
      first_err_addr    <= '0;
      avm.avm_address   <= '0;
      avm.avm_writedata <= '0;
      avm.avm_read      <= 1'b0;
      avm.avm_write     <= 1'b0;
    end else begin
      base_q            <= base_d;
      count_q           <= count_d;
      seed_q            <= seed_d;
      idx_q             <= idx_d;
      rsp_q             <= rsp_d;
      pend_q            <= pend_d;
      busy              <= busy_d;
      done              <= done_d;
      err_count         <= err_d;
      first_err_addr    <= first_d;
      avm.avm_address   <= addr_d;
      avm.avm_writedata <= wdata_d;
      avm.avm_read      <= read_d;
      avm.avm_write     <= write_d;
    end
  end
endmodule

// File: tb/tb_mem_test_master.sv
// Bench for mem_test_master: random-latency/backpressure memory slave,
// pattern reference model and queue scoreboard checked by a monitor.
module tb_mem_test_master;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MAXP   = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   word_count = '0;
  logic [DATA_W-1:0] seed = '0;
  logic              busy, done;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;

  mem_test_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_test_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done),
    .err_count(err_count), .first_err_addr(first_err_addr), .avm(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned due; logic [DATA_W-1:0] data; } rsp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
  typedef struct { logic [15:0] errs; logic [ADDR_W-1:0] first; } res_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  rsp_t rsp_q[$];
  wr_t  exp_wr[$];
  logic [ADDR_W-1:0] exp_rd[$];
  res_t exp_res[$];

  int unsigned cyc = 0, lat = 1, wait_pct = 0;
  int unsigned wr_acc_n = 0, rd_acc_n = 0, first_wr_cyc = 0, last_wr_cyc = 0;
  int unsigned n_cmp = 0, n_bad = 0, done_n = 0, pend = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Memory slave: drives its outputs 1ns after each rising edge.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdata      = '0;
    bus.avm_readdatavalid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.avm_waitrequest   = ($urandom_range(99) < wait_pct);
      bus.avm_readdatavalid = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end
      if (!bus.avm_waitrequest && bus.avm_write) begin
        mem[bus.avm_address] = bus.avm_writedata;
        if (wr_acc_n == 0 || cyc != last_wr_cyc + 1) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_acc_n++;
      end
      if (!bus.avm_waitrequest && bus.avm_read) begin
        rsp_q.push_back('{due: cyc + lat, data: mem[bus.avm_address]});
        rd_acc_n++;
      end
    end
  end

  // Monitor: pops the scoreboard on every bus transfer and done pulse.
  logic              prev_stall = 1'b0;
  logic [43:0]       prev_req = '0;
  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    if (reset) begin
      pend       = 0;
      prev_stall = 1'b0;
    end else begin
      check("rd_wr_exclusive", {63'd0, bus.avm_read & bus.avm_write}, 64'd0);
      if (prev_stall)
        check("stall_hold", {20'd0, bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata},
              {20'd0, prev_req});
      if ((bus.avm_read || bus.avm_write) && !busy) fail_now("busy_low_during_request");
      if (bus.avm_write && !bus.avm_waitrequest) begin
        if (exp_wr.size() == 0) fail_now("unexpected_write");
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", 64'(bus.avm_address), 64'(w.addr));
          check("wr_data", 64'(bus.avm_writedata), 64'(w.data));
        end
      end
      if (bus.avm_read && !bus.avm_waitrequest) begin
        check("pending_limit", {63'd0, pend < MAXP}, 64'd1);
        if (exp_rd.size() == 0) fail_now("unexpected_read");
        else check("rd_addr", 64'(bus.avm_address), 64'(exp_rd.pop_front()));
        pend++;
      end
      if (bus.avm_readdatavalid && pend > 0) pend--;
      if (done) begin
        done_n++;
        check("busy_at_done", {63'd0, busy}, 64'd0);
        if (exp_res.size() == 0) fail_now("unexpected_done");
        else begin
          r = exp_res.pop_front();
          check("err_count", 64'(err_count), 64'(r.errs));
          check("first_err_addr", 64'(first_err_addr), 64'(r.first));
        end
      end
      prev_stall = (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
      prev_req   = {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata};
    end
  end

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Issue one operation; the model predicts writes, read addresses and final result.
  task automatic run_op(input logic m, input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                        input logic [DATA_W-1:0] s, output int unsigned waited);
    res_t r;
    int unsigned errs, d0;
    logic [ADDR_W-1:0] a, first;
    logic [DATA_W-1:0] v;
    errs  = 0;
    first = '0;
    for (int i = 0; i < int'(n); i++) begin
      a = b + ADDR_W'(i);
      v = s + DATA_W'(i);
      if (!m) begin
        exp_wr.push_back('{addr: a, data: v});
        ref_mem[a] = v;
      end else begin
        exp_rd.push_back(a);
        if (ref_mem[a] != v) begin
          if (errs == 0) first = a;
          errs++;
        end
      end
    end
    r.errs  = (errs > 65535) ? 16'hFFFF : 16'(errs);
    r.first = first;
    exp_res.push_back(r);
    d0 = done_n;
    start = 1'b1; mode = m; base_addr = b; word_count = n; seed = s;
    tick();
    start = 1'b0; mode = ~m; base_addr = ADDR_W'($urandom); word_count = '1; seed = $urandom;
    waited = 0;
    while (done_n == d0 && waited < 400 + 40 * int'(n)) begin
      tick();
      waited++;
    end
    if (done_n == d0) fail_now("done_timeout");
    check("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
    check("exp_rd_drained", 64'(exp_rd.size()), 64'd0);
  endtask

  initial begin
    int unsigned k, w0, r0, lb, ln;
    logic [DATA_W-1:0] ls;
    logic [ADDR_W-1:0] ca;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

    tick(3);
    reset = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_read", {63'd0, bus.avm_read}, 64'd0);
    check("rst_write", {63'd0, bus.avm_write}, 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_first_err", 64'(first_err_addr), 64'd0);
    check("rst_address", 64'(bus.avm_address), 64'd0);
    check("rst_writedata", 64'(bus.avm_writedata), 64'd0);
    check("byteenable", 64'(bus.avm_byteenable), 64'hF);

    // Fill with a zero-wait slave, wrapping the top of memory.
    w0 = wr_acc_n;
    run_op(1'b0, 10'h3F0, 11'd32, 32'hDEADBEEF, k);
    check("fill_count", 64'(wr_acc_n - w0), 64'd32);
    check("fill_consecutive", 64'(last_wr_cyc - first_wr_cyc), 64'd31);
    check("fill_word31", 64'(mem[10'h00F]), 64'hDEADBF0E);
    check("fill_word0", 64'(mem[10'h3F0]), 64'hDEADBEEF);

    // Verify, clean then with one and two corrupted words.
    lat = 1;
    run_op(1'b1, 10'h3F0, 11'd32, 32'hDEADBEEF, k);
    check("verify_clean_errs", 64'(err_count), 64'd0);
    mem[10'h3F5] ^= 32'h0000_0100; ref_mem[10'h3F5] ^= 32'h0000_0100;
    run_op(1'b1, 10'h3F0, 11'd32, 32'hDEADBEEF, k);
    check("one_err_count", 64'(err_count), 64'd1);
    check("one_err_addr", 64'(first_err_addr), 64'h3F5);
    mem[10'h004] ^= 32'h8000_0000; ref_mem[10'h004] ^= 32'h8000_0000;
    run_op(1'b1, 10'h3F0, 11'd32, 32'hDEADBEEF, k);
    check("two_err_count", 64'(err_count), 64'd2);
    check("two_err_addr", 64'(first_err_addr), 64'h3F5);

    // Backpressure with long read latency.
    wait_pct = 50;
    lb = $urandom_range(DEPTH - 1);
    ls = $urandom;
    run_op(1'b0, ADDR_W'(lb), 11'd64, ls, k);
    lat = 6;
    run_op(1'b1, ADDR_W'(lb), 11'd64, ls, k);
    check("bp_errs", 64'(err_count), 64'd0);

    // Random mix of fills and verifies, sometimes with a corrupted word.
    ln = 64;
    for (int it = 0; it < 10; it++) begin
      wait_pct = $urandom_range(60);
      lat      = $urandom_range(8, 1);
      if ($urandom_range(1) == 0) begin
        lb = $urandom_range(DEPTH - 1);
        ln = $urandom_range(48, 1);
        ls = $urandom;
        run_op(1'b0, ADDR_W'(lb), ADDR_W'(ln), ls, k);
      end else begin
        if ($urandom_range(1) == 1) begin
          ca = ADDR_W'(lb + $urandom_range(ln - 1));
          v_flip(ca);
        end
        run_op(1'b1, ADDR_W'(lb), ADDR_W'(ln), ls, k);
      end
    end

    // Zero-length command: done only, no bus traffic.
    wait_pct = 0;
    w0 = wr_acc_n;
    r0 = rd_acc_n;
    run_op(1'b0, 10'h123, 11'd0, 32'h1, k);
    check("count0_done_latency", {63'd0, k <= 2}, 64'd1);
    check("count0_no_writes", 64'(wr_acc_n - w0), 64'd0);
    run_op(1'b1, 10'h123, 11'd0, 32'h1, k);
    check("count0_no_reads", 64'(rd_acc_n - r0), 64'd0);

    // Reset in the middle of a verify with reads outstanding.
    lat = 3;
    run_op(1'b0, 10'h100, 11'd40, 32'h0BAD_F00D, k);
    mem[10'h101] ^= 32'h1; ref_mem[10'h101] ^= 32'h1;
    for (int i = 0; i < 40; i++) exp_rd.push_back(ADDR_W'(10'h100 + i));
    r0 = rd_acc_n;
    start = 1'b1; mode = 1'b1; base_addr = 10'h100; word_count = 11'd40; seed = 32'h0BAD_F00D;
    tick();
    start = 1'b0;
    k = 0;
    while (rd_acc_n - r0 < 10 && k < 200) begin
      tick();
      k++;
    end
    if (rd_acc_n - r0 < 10) fail_now("reset_setup_timeout");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_rd.delete();
    check("rst_mid_read_low", {63'd0, bus.avm_read}, 64'd0);
    check("rst_mid_busy_low", {63'd0, busy}, 64'd0);
    check("rst_mid_err_count", 64'(err_count), 64'd0);
    k = done_n;
    tick(20);
    check("rst_mid_no_done", 64'(done_n), 64'(k));
    check("rst_mid_err_after_stale", 64'(err_count), 64'd0);
    check("stale_drained", 64'(rsp_q.size()), 64'd0);
    mem[10'h101] ^= 32'h1; ref_mem[10'h101] ^= 32'h1;
    run_op(1'b1, 10'h100, 11'd40, 32'h0BAD_F00D, k);
    check("post_reset_errs", 64'(err_count), 64'd0);

    tick(5);
    check("results_drained", 64'(exp_res.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic v_flip(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] m;
    m = DATA_W'(1) << $urandom_range(DATA_W - 1);
    mem[a]     ^= m;
    ref_mem[a] ^= m;
  endtask
endmodule
